// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- valid/stall/flush/multicycle controller for a linear pipeline.
// Drives per-register load enables and clears for an external datapath and
// keeps a shadow valid bit for every register.
// Optional build macro: PIPE_CTRL_BUBBLE_COLLAPSE_EN. When it is defined, an
// empty register never holds, so upstream items can advance into the bubble
// behind a stall. When it is undefined, a hold reaches every upstream register.
//
// Multicycle timing: an accepted mc_start with a nonzero mc_len holds
// register MC_STAGE in its start cycle. The counter then keeps it held for
// mc_len more cycles, during which mc_busy is high.
module pipe_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int MC_STAGE   = 2,
    parameter int MC_CNT_W   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_STAGES-1:0]         stall_req,
    input  logic                          flush_req,
    input  logic [$clog2(NUM_STAGES)-1:0] flush_stage,
    input  logic                          mc_start,
    input  logic [MC_CNT_W-1:0]           mc_len,
    output logic                          mc_busy,
    output logic [NUM_STAGES-1:0]         en,
    output logic [NUM_STAGES-1:0]         squash,
    output logic [NUM_STAGES-1:0]         valid_q,
    output logic                          out_valid
);

    logic [MC_CNT_W-1:0]   mc_cnt_q;
    logic [MC_CNT_W-1:0]   mc_cnt_d;
    logic [NUM_STAGES-1:0] valid_d;
    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] hold_raw;
    logic [NUM_STAGES-1:0] mcx;
    logic [NUM_STAGES-1:0] flush_mask;
    logic                  mc_go;
    logic                  mc_hold;
    logic                  mc_kill;
    logic                  accept;

    // A new operation may start only on a valid item while the counter is idle.
    assign mc_busy = (mc_cnt_q != '0);
    assign mc_go   = mc_start & valid_q[MC_STAGE] & ~mc_busy;
    // A zero-length operation never holds. A nonzero one holds from its start cycle.
    assign mc_hold = mc_busy | (mc_go & (mc_len != '0));
    // A flush that reaches the multicycle register cancels the operation.
    assign mc_kill = flush_req & (int'(flush_stage) >= MC_STAGE);

    assign in_ready  = ~reset & ~hold[0] & ~flush_req;
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_q[NUM_STAGES-1] & ~hold[NUM_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign mcx[gi] = (gi == MC_STAGE) ? mc_hold : 1'b0;

            // A hold ripples from the oldest register back towards register 0.
            if (gi == NUM_STAGES - 1) begin : g_last
                assign hold_raw[gi] = stall_req[gi] | mcx[gi];
            end else begin : g_mid
                assign hold_raw[gi] = stall_req[gi] | mcx[gi] | hold[gi+1];
            end

`ifdef PIPE_CTRL_BUBBLE_COLLAPSE_EN
            assign hold[gi] = hold_raw[gi] & valid_q[gi];
`else
            assign hold[gi] = hold_raw[gi];
`endif

            assign flush_mask[gi] = flush_req & (int'(flush_stage) >= gi);
            assign en[gi]         = ~reset & ~hold[gi];

            // Register 0 clears when it loads without an accepted item.
            // A later register clears when its upstream neighbour holds,
            // so a held item is never copied forward.
            if (gi == 0) begin : g_sq0
                assign squash[gi] = reset | flush_mask[gi] | (~hold[gi] & ~accept);
                assign valid_d[gi] = squash[gi] ? 1'b0 :
                                     (en[gi] ? accept : valid_q[gi]);
            end else begin : g_sqn
                assign squash[gi] = reset | flush_mask[gi] | (hold[gi-1] & ~hold[gi]);
                assign valid_d[gi] = squash[gi] ? 1'b0 :
                                     (en[gi] ? valid_q[gi-1] : valid_q[gi]);
            end
        end
    endgenerate

    // Multicycle counter next state: flush cancels, start loads, busy counts down.
    always_comb begin
        mc_cnt_d = mc_cnt_q;
        if (mc_kill) begin
            mc_cnt_d = '0;
        end else if (mc_go) begin
            mc_cnt_d = mc_len;
        end else if (mc_busy) begin
            mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
        end
    end

    // State registers: reset drops every valid bit and the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            mc_cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

endmodule
